// File: rtl/cozy_fetch_unit.sv
// -----------------------------------------------------------------------------
// cozy_fetch_unit
//   Instruction fetch sequencer for the cozy core. Issues word reads on a
//   req/ack memory bus, buffers fetched words in a small prefetch FIFO and
//   hands them, with their PC, to decode over a valid/ready handshake.
//   A redirect flushes the FIFO and restarts fetch at a new PC. A bus read
//   cannot be aborted, so a redirect that lands on an outstanding request
//   waits for that request's ack and throws the returned data away.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   mem_req / mem_addr     read request and word address (held until mem_ack)
//   mem_ack / mem_rdata    read completion and returned word
//   redirect / redirect_pc one-cycle flush pulse and new fetch address
//   insn_valid/insn_ready  head-of-FIFO handshake towards decode
//   insn / insn_pc         head instruction word and its address (registered)
//   busy                   a bus request is outstanding (equals mem_req)
// -----------------------------------------------------------------------------
module cozy_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [15:0]       insn,
    output logic [ADDR_W-1:0] insn_pc,
    output logic              busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDR_W + 16;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
    localparam logic [PW-1:0]     PTR_ZERO = {PW{1'b0}};
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t              state_r, state_n;
    logic                mem_req_r, mem_req_n;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_n;
    logic [ADDR_W-1:0]   fetch_pc_r, fetch_pc_n;

    logic [EW-1:0]       fifo_r [DEPTH];
    logic [PW-1:0]       rd_ptr_r, wr_ptr_r;
    logic [CW-1:0]       count_r, count_n;

    logic                insn_valid_r;
    logic [15:0]         insn_r;
    logic [ADDR_W-1:0]   insn_pc_r;

    logic                ack_s, push_s, pop_s;
    logic [CW-1:0]       remain_s;
    logic [PW-1:0]       head_idx_s;
    logic [EW-1:0]       head_n;
    logic [ADDR_W-1:0]   target_s;

    // FIFO bookkeeping: push/pop qualification, next occupancy, next head entry
    always_comb begin
        ack_s      = mem_ack & mem_req_r;
        // only a live REQ transaction delivers data; redirect drops it
        push_s     = ack_s & (state_r == ST_REQ) & ~redirect;
        pop_s      = insn_valid_r & insn_ready;
        remain_s   = count_r - CW'(pop_s);
        head_idx_s = rd_ptr_r + PW'(pop_s);
        if (redirect) begin
            count_n = CNT_ZERO;
        end else begin
            count_n = remain_s + CW'(push_s);
        end
        // after the pop, either an older entry becomes head or the word
        // arriving this cycle does (FIFO drained to empty)
        if (remain_s != CNT_ZERO) begin
            head_n = fifo_r[head_idx_s];
        end else begin
            head_n = {mem_addr_r, mem_rdata};
        end
    end

    // FIFO storage and pointers; redirect rewinds both pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= {EW{1'b0}};
            end
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= {mem_addr_r, mem_rdata};
            end
            if (redirect) begin
                rd_ptr_r <= PTR_ZERO;
                wr_ptr_r <= PTR_ZERO;
            end else begin
                rd_ptr_r <= rd_ptr_r + PW'(pop_s);
                wr_ptr_r <= wr_ptr_r + PW'(push_s);
            end
            count_r <= count_n;
        end
    end

    // Registered head-of-FIFO presentation towards decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_valid_r <= 1'b0;
            insn_r       <= 16'h0000;
            insn_pc_r    <= {ADDR_W{1'b0}};
        end else begin
            insn_valid_r <= (count_n != CNT_ZERO);
            if (count_n != CNT_ZERO) begin
                insn_pc_r <= head_n[EW-1:16];
                insn_r    <= head_n[15:0];
            end
        end
    end

    // Fetch FSM next-state and next bus outputs
    always_comb begin
        state_n    = state_r;
        mem_req_n  = mem_req_r;
        mem_addr_n = mem_addr_r;
        fetch_pc_n = fetch_pc_r;
        target_s   = redirect ? redirect_pc : fetch_pc_r;
        case (state_r)
            ST_IDLE: begin
                fetch_pc_n = target_s;
                if (redirect || (count_r < DEPTH_C)) begin
                    state_n    = ST_REQ;
                    mem_req_n  = 1'b1;
                    mem_addr_n = target_s;
                end else begin
                    state_n    = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    fetch_pc_n = redirect_pc;
                    if (ack_s) begin
                        // FIFO is flushed, so a slot is always free
                        mem_addr_n = redirect_pc;
                    end else begin
                        // request cannot be withdrawn; wait out its ack
                        state_n = ST_DISCARD;
                    end
                end else if (ack_s) begin
                    fetch_pc_n = fetch_pc_r + PC_ONE;
                    mem_addr_n = fetch_pc_r + PC_ONE;
                    if (count_n < DEPTH_C) begin
                        state_n = ST_REQ;
                    end else begin
                        state_n   = ST_IDLE;
                        mem_req_n = 1'b0;
                    end
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_DISCARD: begin
                // a later redirect simply replaces the pending target
                fetch_pc_n = target_s;
                if (ack_s) begin
                    mem_addr_n = target_s;
                    if (count_n < DEPTH_C) begin
                        state_n = ST_REQ;
                    end else begin
                        state_n   = ST_IDLE;
                        mem_req_n = 1'b0;
                    end
                end else begin
                    state_n = ST_DISCARD;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                mem_req_n  = 1'b0;
                mem_addr_n = fetch_pc_r;
            end
        endcase
    end

    // Fetch FSM state and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
            fetch_pc_r <= RESET_PC;
        end else begin
            state_r    <= state_n;
            mem_req_r  <= mem_req_n;
            mem_addr_r <= mem_addr_n;
            fetch_pc_r <= fetch_pc_n;
        end
    end

    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign busy       = mem_req_r;
    assign insn_valid = insn_valid_r;
    assign insn       = insn_r;
    assign insn_pc    = insn_pc_r;

endmodule
